// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes, slave FSM states and the byte-lane strobe helper.
package ahb_pkg;

  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_t;

  typedef enum logic [2:0] {
    HS_BYTE, HS_HALF, HS_WORD, HS_DWORD, HS_4W, HS_8W, HS_16W, HS_32W
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} slv_state_t;

  // Little-endian lane enables for up to 8 lanes; callers keep the low DATA_W/8 bits.
  function automatic logic [7:0] strobe(input logic [2:0] hsize, input logic [2:0] addr_lsb);
    logic [7:0] base;
    case (hsize)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr_lsb;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-port bundle; hready is the bus-level ready fed back from the selected slave.
interface ahb_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slv_decode.sv
// Address-phase decode: word index, lane strobe and (with AHB_SLV_ERR_EN) legality check.
module ahb_slv_decode
  import ahb_pkg::*;
#(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
)(
  input  logic [ADDR_W-1:0]              haddr,
  input  logic [2:0]                     hsize,
  output logic [$clog2(DEPTH_WORDS)-1:0] idx,
  output logic [DATA_W/8-1:0]            strb
`ifdef AHB_SLV_ERR_EN
  ,output logic                          illegal
`endif
);
  localparam int NB    = DATA_W / 8;
  localparam int LSB_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [ADDR_W-1:0] off;
  logic [2:0]        lsb3;
  logic [7:0]        s8;

  always_comb begin
    off  = haddr - BASE_ADDR;
    idx  = off[LSB_W +: IDX_W];
    lsb3 = 3'(haddr[LSB_W-1:0]);
    s8   = strobe(hsize, lsb3);
    strb = s8[NB-1:0];
  end

`ifdef AHB_SLV_ERR_EN
  localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(DEPTH_WORDS * NB);
  localparam logic [2:0]      MAX_SIZE = 3'(LSB_W);

  logic [7:0] amask;

  // Below-base addresses wrap to a huge offset, so one compare covers both ends.
  always_comb begin
    amask   = 8'((9'd1 << hsize) - 9'd1);
    illegal = ({1'b0, off} >= SPAN) || (hsize > MAX_SIZE) || (|(haddr[7:0] & amask));
  end
`endif

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with programmable wait states and byte-lane writes.
// Define AHB_SLV_ERR_EN to enable legality checks and the two-cycle ERROR response.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
)(
  input logic               hclk,
  input logic               hrstn,
  ahb_slave_mem_if.slave    bus
);
  localparam int         NB    = DATA_W / 8;
  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  slv_state_t       state;
  logic [3:0]       cnt;
  logic             rdy_q;
  logic             write_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NB-1:0]    strb_q, strb_d;
  logic             accept;

`ifdef AHB_SLV_ERR_EN
  logic resp_q, illegal_d;
`endif

  ahb_slv_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .haddr  (bus.haddr),
    .hsize  (bus.hsize),
    .idx    (idx_d),
    .strb   (strb_d)
`ifdef AHB_SLV_ERR_EN
    ,.illegal(illegal_d)
`endif
  );

  assign accept = bus.hsel & bus.hready & bus.htrans[1] & rdy_q;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdy_q   <= 1'b1;
      write_q <= 1'b0;
      idx_q   <= '0;
      strb_q  <= '0;
`ifdef AHB_SLV_ERR_EN
      resp_q  <= HRESP_OKAY;
`endif
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_DATA;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef AHB_SLV_ERR_EN
        ST_ERR1: begin
          state <= ST_ERR2;
          rdy_q <= 1'b1;
        end
`endif
        // IDLE, DATA and ERR2 all present hreadyout=1 and can take a new address phase.
        default: begin
`ifdef AHB_SLV_ERR_EN
          resp_q <= HRESP_OKAY;
`endif
          if (accept) begin
            write_q <= bus.hwrite;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
`ifdef AHB_SLV_ERR_EN
            if (illegal_d) begin
              state  <= ST_ERR1;
              rdy_q  <= 1'b0;
              resp_q <= HRESP_ERROR;
            end else
`endif
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
              cnt   <= WS_M1;
              rdy_q <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Commit at the edge ending DATA; an async reset drops state first, so no commit.
  always_ff @(posedge hclk) begin
    if (state == ST_DATA && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem[idx_q][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
      end
    end
  end

  assign bus.hreadyout = rdy_q;
  assign bus.hrdata    = (state == ST_DATA && !write_q) ? mem[idx_q] : '0;
`ifdef AHB_SLV_ERR_EN
  assign bus.hresp     = resp_q;
`else
  assign bus.hresp     = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: three slaves (0, 3 and 2 wait states) sharing one stimulus bus.
// Error-response checks are built when AHB_SLV_ERR_EN is defined, wrap checks otherwise.
module tb_ahb_slave_mem;
  logic        hclk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  sel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  rdy, resp;
  logic [31:0] rdata [3];

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    ahb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.hsel   = sel[g];
    assign bus.haddr  = haddr;
    assign bus.htrans = htrans;
    assign bus.hwrite = hwrite;
    assign bus.hsize  = hsize;
    assign bus.hburst = 3'd0;
    assign bus.hwdata = hwdata;
    assign bus.hready = bus.hreadyout;
    assign rdy[g]     = bus.hreadyout;
    assign resp[g]    = bus.hresp;
    assign rdata[g]   = bus.hrdata;
    ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024),
                    .BASE_ADDR(32'h0), .WAIT_STATES(WS)) dut (
      .hclk (hclk),
      .hrstn(rstn[g]),
      .bus  (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_phase(input int k, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    sel    = 3'b001 << k;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    sel    = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // One isolated transfer; returns data/resp of the first ready cycle and the count of stall cycles.
  task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int low,
                      output logic rsp);
    addr_phase(k, wr, a, sz);
    step();
    bus_idle();
    hwdata = wd;
    low = 0;
    rd  = '0;
    rsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      if (rdy[k]) begin
        rd  = rdata[k];
        rsp = resp[k];
        break;
      end
      low++;
      step();
    end
    step();
  endtask

  logic [31:0] rd;
  int          low;
  logic        rsp;

  initial begin
    rstn = '0;
    bus_idle();
    haddr = '0; hsize = 3'd2; hwdata = '0;

    #12;
    chk("rst_rdy0",  32'(rdy[0]),  32'd1);
    chk("rst_resp0", 32'(resp[0]), 32'd0);
    chk("rst_data0", rdata[0],     32'd0);
    chk("rst_rdy1",  32'(rdy[1]),  32'd1);
    chk("rst_data1", rdata[1],     32'd0);
    #18 rstn = '1;
    step();
    chk("post_rst_rdy0", 32'(rdy[0]), 32'd1);

    // zero wait states: write then read
    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, low, rsp);
    chk("ws0_wr_low", 32'(low), 32'd0);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, low, rsp);
    chk("ws0_rd_low",  32'(low), 32'd0);
    chk("ws0_rd_data", rd,       32'hDEADBEEF);
    chk("ws0_rd_resp", 32'(rsp), 32'd0);

    // back-to-back write then read of the same word
    addr_phase(0, 1'b1, 32'h20, 3'd2);
    step();
    hwdata = 32'hCAFEF00D;
    addr_phase(0, 1'b0, 32'h20, 3'd2);
    @(negedge hclk);
    chk("b2b_wr_rdy", 32'(rdy[0]), 32'd1);
    step();
    bus_idle();
    @(negedge hclk);
    chk("b2b_rd_rdy",  32'(rdy[0]), 32'd1);
    chk("b2b_rd_data", rdata[0],    32'hCAFEF00D);
    step();
    @(negedge hclk);
    chk("idle_data0", rdata[0], 32'd0);
    step();

    // byte and halfword lane writes; other lanes of hwdata carry junk
    xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, low, rsp);
    xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA123456, rd, low, rsp);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, low, rsp);
    chk("byte_wr", rd, 32'hAA223344);
    xfer(0, 1'b1, 32'h10, 3'd1, 32'hFFFF5566, rd, low, rsp);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, low, rsp);
    chk("half_wr", rd, 32'hAA225566);

    // three wait states
    xfer(1, 1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, low, rsp);
    chk("ws3_wr_low", 32'(low), 32'd3);
    xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, low, rsp);
    chk("ws3_rd_low",  32'(low), 32'd3);
    chk("ws3_rd_data", rd,       32'h0BADF00D);

    // reset during the wait of a write must not commit it
    xfer(2, 1'b1, 32'h20, 3'd2, 32'h12345678, rd, low, rsp);
    chk("ws2_wr_low", 32'(low), 32'd2);
    addr_phase(2, 1'b1, 32'h20, 3'd2);
    step();
    bus_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("ws2_in_wait", 32'(rdy[2]), 32'd0);
    rstn[2] = 1'b0;
    #1;
    chk("mid_rst_rdy",  32'(rdy[2]),  32'd1);
    chk("mid_rst_resp", 32'(resp[2]), 32'd0);
    chk("mid_rst_data", rdata[2],     32'd0);
    step();
    step();
    rstn[2] = 1'b1;
    step();
    xfer(2, 1'b0, 32'h20, 3'd2, 32'h0, rd, low, rsp);
    chk("ws2_rd_low",  32'(low), 32'd2);
    chk("ws2_old_data", rd,      32'h12345678);

`ifdef AHB_SLV_ERR_EN
    xfer(0, 1'b1, 32'h0, 3'd2, 32'h600DF00D, rd, low, rsp);
    // out of range read, then a pipelined good read in the ERR2 cycle
    addr_phase(0, 1'b0, 32'h1000, 3'd2);
    step();
    bus_idle();
    @(negedge hclk);
    chk("oor_c1_rdy",  32'(rdy[0]),  32'd0);
    chk("oor_c1_resp", 32'(resp[0]), 32'd1);
    step();
    addr_phase(0, 1'b0, 32'h0, 3'd2);
    @(negedge hclk);
    chk("oor_c2_rdy",  32'(rdy[0]),  32'd1);
    chk("oor_c2_resp", 32'(resp[0]), 32'd1);
    step();
    bus_idle();
    @(negedge hclk);
    chk("after_err_rdy",  32'(rdy[0]),  32'd1);
    chk("after_err_resp", 32'(resp[0]), 32'd0);
    chk("after_err_data", rdata[0],     32'h600DF00D);
    step();
    // misaligned word
    addr_phase(0, 1'b0, 32'h2, 3'd2);
    step();
    bus_idle();
    @(negedge hclk);
    chk("mis_c1_rdy",  32'(rdy[0]),  32'd0);
    chk("mis_c1_resp", 32'(resp[0]), 32'd1);
    step();
    @(negedge hclk);
    chk("mis_c2_rdy",  32'(rdy[0]),  32'd1);
    chk("mis_c2_resp", 32'(resp[0]), 32'd1);
    step();
    @(negedge hclk);
    chk("mis_done_resp", 32'(resp[0]), 32'd0);
    step();
    // oversize on a 32-bit bus
    addr_phase(0, 1'b0, 32'h8, 3'd3);
    step();
    bus_idle();
    @(negedge hclk);
    chk("big_c1_resp", 32'(resp[0]), 32'd1);
    step();
    step();
`else
    // without checks, out-of-range wraps and misaligned uses the truncated index
    xfer(0, 1'b1, 32'h1030, 3'd2, 32'h5A5A5A5A, rd, low, rsp);
    chk("wrap_wr_resp", 32'(rsp), 32'd0);
    xfer(0, 1'b0, 32'h30, 3'd2, 32'h0, rd, low, rsp);
    chk("wrap_rd_data", rd, 32'h5A5A5A5A);
    xfer(0, 1'b0, 32'h32, 3'd2, 32'h0, rd, low, rsp);
    chk("mis_rd_data", rd,       32'h5A5A5A5A);
    chk("mis_rd_resp", 32'(rsp), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
